convert_bit_16be: RTL and testbench
===================================

# convert_bit_16be

Single-cycle, registered converter from an IEEE-754 binary16 (half-precision) value to an IEEE-754 binary32 (single-precision) value. The binary16 value arrives as a big-endian halfword in the upper half of a 32-bit input word. The block sits between the 16-bit sample stream loader and the 32-bit floating-point datapath, producing one converted word per clock. The conversion is exact: every binary16 value, including subnormals, is representable in binary32.

## Interface
Parameters:
- LITTLE_ENDIAN_IN, default 0. 0: in[31:24] is the MSB byte of the halfword. 1: in[31:24] is the LSB byte, so the bytes are swapped before decoding.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in   input  32  in[31:16] holds the binary16 halfword (byte order per LITTLE_ENDIAN_IN); in[15:0] ignored
- out  output 32  binary32 result, registered

## Operation
- Halfword h is split into fields: s = h[15], e = h[14:10], m = h[9:0]. The result is {S, E[7:0], F[22:0]}, where S = s in all cases.
- Zero (e=0, m=0): E=0, F=0. Signed zero is preserved.
- Subnormal (e=0, m≠0):
  - p = bit index of the MSB set in m (0..9).
  - E = 103 + p.
  - F = bits of m below position p, left-aligned into F[22:0]; the remaining low bits are 0.
- Normal (1 ≤ e ≤ 30): E = e + 112; F = {m, 13'b0}.
- Infinity (e=31, m=0): E=8'hFF, F=0.
- NaN (e=31, m≠0): E=8'hFF, F = {m, 13'b0} with F[22] forced to 1 (quieted). The payload is otherwise preserved.
- No rounding and no exception flags; the mapping is a pure function of h.

## Timing
- Latency 1 clock. out at edge k+1 reflects in sampled at edge k.
- Throughput: one conversion per clock. No handshake; every cycle is valid.
- Reset: while rst=1 at a rising edge, out ← 32'h0000_0000.
- Reset mid-stream: the output is 0 for each reset cycle. The first edge after rst deasserts registers the conversion of the input present at that edge.
- The input need not be held stable beyond the setup window of the sampling edge.

## Structure
- Shared package fp_conv_pkg holds:
  - field widths: FP16 exponent 5, mantissa 10; FP32 exponent 8, mantissa 23
  - biases: 15 and 127, plus the bias delta 112
  - subnormal base exponent 103
  - constants FP32_EXP_MAX = 8'hFF and QNAN_BIT = 22
- One sub-module, lzc10: combinational leading-zero count of the 10-bit mantissa. It returns the 4-bit position p and a zero flag, and drives the subnormal normalization shift.
- Top level contains:
  - byte-order mux
  - field decode
  - class select (zero / subnormal / normal / inf / NaN)
  - normalization shifter
  - output register

## Test plan
- Normal values: 0x3C00→0x3F800000 (1.0); 0xC000→0xC0000000 (−2.0); 0x7BFF→0x477FE000 (65504). Each appears one cycle after the input is applied.
- Zeros and infinities: 0x0000→0x00000000; 0x8000→0x80000000; 0x7C00→0x7F800000; 0xFC00→0xFF800000.
- Subnormals: 0x0001→0x33800000; 0x03FF→0x387FC000; 0x8200→0xB8000000.
- NaN quieting: 0x7C01→0x7FC02000; 0x7E00→0x7FC00000; 0xFDFF→0xFFFFE000.
- Byte order and ignored bits: with LITTLE_ENDIAN_IN=1, in=0x003C_ABCD→0x3F800000. With LITTLE_ENDIAN_IN=0, changing in[15:0] does not change out.
- Reset and streaming:
  - Apply 20 back-to-back words; each out matches its input delayed by exactly one clock.
  - Assert rst for 2 cycles mid-stream: out=0 during reset, then conversion resumes on the next edge.

Source files
------------

// File: rtl/fp_conv_pkg.sv
// fp_conv_pkg: shared binary16/binary32 field widths, biases and class encoding
package fp_conv_pkg;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_BIAS = 15;
  localparam int FP32_BIAS = 127;
  localparam int BIAS_DELTA = FP32_BIAS - FP16_BIAS;
  localparam int SUB_BASE_EXP = 103;
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_MAX = 8'hFF;
  localparam int QNAN_BIT = 22;
  typedef enum logic [2:0] {CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;
endpackage

// File: rtl/lzc10.sv
// lzc10: MSB position p_o of 10-bit m_i and all-zero flag zero_o (combinational)
module lzc10 (
  input  logic [9:0] m_i,
  output logic [3:0] p_o,
  output logic       zero_o
);
  always_comb begin
    p_o = '0;
    for (int i = 0; i < 10; i++) if (m_i[i]) p_o = 4'(i);
  end
  assign zero_o = ~|m_i;
endmodule

// File: rtl/convert_bit_16be.sv
// convert_bit_16be: registered binary16 (in[31:16]) to binary32 (out) converter, clk/rst sync active-high
module convert_bit_16be
  import fp_conv_pkg::*;
#(
  parameter bit LITTLE_ENDIAN_IN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  output logic [31:0] out
);
  logic [15:0] h;
  logic s;
  logic [FP16_EXP_W-1:0] e;
  logic [FP16_MAN_W-1:0] m, sub_m;
  logic [3:0] p;
  logic m_zero;
  fp_class_e cls;
  logic [FP32_EXP_W-1:0] exp_d;
  logic [FP32_MAN_W-1:0] frac_d;
  logic [31:0] out_d, out_q;
  logic unused_lo;
  assign unused_lo = ^in[15:0];
  assign h = LITTLE_ENDIAN_IN ? {in[23:16], in[31:24]} : in[31:16];
  assign {s, e, m} = h;
  lzc10 u_lzc (.m_i(m), .p_o(p), .zero_o(m_zero));
  // shifting by 10-p pushes the leading one out of the 10-bit field
  assign sub_m = m << (4'd10 - p);
  always_comb begin
    cls = (e == '0) ? (m_zero ? CLS_ZERO : CLS_SUB) : (&e) ? (m_zero ? CLS_INF : CLS_NAN) : CLS_NORM;
    exp_d = cls == CLS_ZERO ? '0 :
            cls == CLS_SUB  ? 8'(SUB_BASE_EXP) + {4'd0, p} :
            cls == CLS_NORM ? {3'd0, e} + 8'(BIAS_DELTA) : FP32_EXP_MAX;
    frac_d = cls == CLS_ZERO ? '0 :
             cls == CLS_SUB  ? {sub_m, 13'd0} :
             cls == CLS_NORM ? {m, 13'd0} :
             cls == CLS_INF  ? '0 : ({m, 13'd0} | (23'd1 << QNAN_BIT));
    out_d = {s, exp_d, frac_d};
  end
  always_ff @(posedge clk) out_q <= rst ? '0 : out_d;
  assign out = out_q;
endmodule

// File: tb/tb_convert_bit_16be.sv
// tb_convert_bit_16be: vector table, streaming, reset and random checks against an arithmetic model
module tb_convert_bit_16be;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in_be = '0, in_le = '0;
  logic [31:0] out_be, out_le;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  convert_bit_16be #(.LITTLE_ENDIAN_IN(1'b0)) dut (.clk(clk), .rst(rst), .in(in_be), .out(out_be));
  convert_bit_16be #(.LITTLE_ENDIAN_IN(1'b1)) dut_le (.clk(clk), .rst(rst), .in(in_le), .out(out_le));
  typedef struct {logic [15:0] h; logic [31:0] exp;} vec_t;
  vec_t vecs[16];
  function automatic logic [31:0] ref_conv(input logic [15:0] h);
    int e, m, ex, mant;
    logic [7:0] ef;
    logic [22:0] ff;
    e = {27'd0, h[14:10]};
    m = {22'd0, h[9:0]};
    if (e == 31) begin
      ef = 8'hFF;
      ff = (m == 0) ? 23'd0 : 23'((m * 8192) + 4194304 * ((m < 512) ? 1 : 0));
    end else if (e == 0 && m == 0) begin
      ef = 8'd0;
      ff = 23'd0;
    end else begin
      mant = (e == 0) ? m : m + 1024;
      ex = (e == 0) ? -14 : e - 15;
      while (mant < 1024) begin
        mant = mant * 2;
        ex = ex - 1;
      end
      ef = 8'(ex + 127);
      ff = 23'((mant - 1024) * 8192);
    end
    return {h[15], ef, ff};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] b);
    in_be = a;
    in_le = b;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] rand_h();
    logic [15:0] h;
    int r;
    h = 16'($urandom);
    r = $urandom_range(0, 3);
    if (r == 0) h[14:10] = 5'd0;
    if (r == 1) h[14:10] = 5'd31;
    return h;
  endfunction
  initial begin
    logic [15:0] h, prev;
    vecs = '{
      '{16'h3C00, 32'h3F800000}, '{16'hC000, 32'hC0000000}, '{16'h7BFF, 32'h477FE000},
      '{16'h0000, 32'h00000000}, '{16'h8000, 32'h80000000}, '{16'h7C00, 32'h7F800000},
      '{16'hFC00, 32'hFF800000}, '{16'h0001, 32'h33800000}, '{16'h03FF, 32'h387FC000},
      '{16'h8200, 32'hB8000000}, '{16'h7C01, 32'h7FC02000}, '{16'h7E00, 32'h7FC00000},
      '{16'hFDFF, 32'hFFFFE000}, '{16'h0200, 32'h38000000}, '{16'h0400, 32'h38800000},
      '{16'h3555, 32'h3EAAA000}};
    step(32'h3C00_0000, 32'h003C_0000);
    step(32'h3C00_0000, 32'h003C_0000);
    chk("reset_be", out_be, 32'h0);
    chk("reset_le", out_le, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step({vecs[i].h, 16'($urandom)}, {vecs[i].h[7:0], vecs[i].h[15:8], 16'($urandom)});
      chk($sformatf("vec%0d_be", i), out_be, vecs[i].exp);
      chk($sformatf("vec%0d_le", i), out_le, vecs[i].exp);
      chk($sformatf("model%0d", i), ref_conv(vecs[i].h), vecs[i].exp);
    end
    step(32'h3C00_0000, 32'h003C_ABCD);
    chk("le_abcd", out_le, 32'h3F800000);
    step(32'h3C00_FFFF, 32'h003C_1234);
    chk("low_ignored_be", out_be, 32'h3F800000);
    chk("low_ignored_le", out_le, 32'h3F800000);
    prev = 16'h3C00;
    for (int i = 0; i < 20; i++) begin
      h = rand_h();
      in_be = {h, 16'($urandom)};
      in_le = {h[7:0], h[15:8], 16'($urandom)};
      #1;
      chk("stream_hold", out_be, ref_conv(prev));
      @(posedge clk);
      #1;
      chk("stream_be", out_be, ref_conv(h));
      chk("stream_le", out_le, ref_conv(h));
      prev = h;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      h = rand_h();
      step({h, 16'h0}, {h[7:0], h[15:8], 16'h0});
      chk("midreset_be", out_be, 32'h0);
      chk("midreset_le", out_le, 32'h0);
    end
    rst = 1'b0;
    h = 16'h3C00;
    step({h, 16'h0}, {h[7:0], h[15:8], 16'h0});
    chk("resume_be", out_be, 32'h3F800000);
    chk("resume_le", out_le, 32'h3F800000);
    for (int i = 0; i < 300; i++) begin
      h = rand_h();
      step({h, 16'($urandom)}, {h[7:0], h[15:8], 16'($urandom)});
      chk("rand_be", out_be, ref_conv(h));
      chk("rand_le", out_le, ref_conv(h));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
